// File: rtl/mult_div_unit_pkg.sv
// Shared MDU constants: opcode encodings, opcode width and a small helper.
// Eight operations plus the MDU_none default are nine codes, so the opcode
// field is four bits wide.
package mult_div_unit_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] MDU_none  = 4'd0;
   localparam logic [OP_W-1:0] MDU_mult  = 4'd1;
   localparam logic [OP_W-1:0] MDU_multu = 4'd2;
   localparam logic [OP_W-1:0] MDU_div   = 4'd3;
   localparam logic [OP_W-1:0] MDU_divu  = 4'd4;
   localparam logic [OP_W-1:0] MDU_mfhi  = 4'd5;
   localparam logic [OP_W-1:0] MDU_mflo  = 4'd6;
   localparam logic [OP_W-1:0] MDU_mthi  = 4'd7;
   localparam logic [OP_W-1:0] MDU_mtlo  = 4'd8;

   function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit sitting beside the ALU in EX.
// Results are computed combinationally on accept into pending registers and
// only copied to the architectural HI/LO after a fixed busy countdown, so
// HI/LO never expose in-flight values.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, op           MDU instruction present this cycle and its opcode
//   src_a, src_b        rs / rt operands
//   busy                multi-cycle operation in flight
//   hi, lo              committed HI/LO registers
//   rd_data             hi for MFHI, lo for MFLO, else 0 (combinational)
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned CNT_W = $clog2(max_uint(MUL_CYCLES, DIV_CYCLES) + 1);

   logic [CNT_W-1:0]   counter;
   logic [WIDTH-1:0]   pend_hi;
   logic [WIDTH-1:0]   pend_lo;

   logic               a_neg;
   logic               b_neg;
   logic               b_zero;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   bm_safe;
   logic [WIDTH-1:0]   mag_q;
   logic [WIDTH-1:0]   mag_r;
   logic [WIDTH-1:0]   div_q;
   logic [WIDTH-1:0]   div_r;
   logic [WIDTH-1:0]   divu_q;
   logic [WIDTH-1:0]   divu_r;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;

   // Result datapath. Signed division works on magnitudes and fixes signs
   // afterwards; for MIN / -1 the magnitude quotient is already the bit
   // pattern of MIN and the remainder is 0, so no special case is needed.
   always_comb begin
      a_neg   = src_a[WIDTH-1];
      b_neg   = src_b[WIDTH-1];
      b_zero  = (src_b == '0);
      a_mag   = a_neg ? -src_a : src_a;
      b_mag   = b_neg ? -src_b : src_b;
      // Divisor forced nonzero so the dividers never see 0; result overridden below.
      b_safe  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : src_b;
      bm_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
      mag_q   = a_mag / bm_safe;
      mag_r   = a_mag % bm_safe;
      div_q   = b_zero ? '1 : ((a_neg ^ b_neg) ? -mag_q : mag_q);
      div_r   = b_zero ? src_a : (a_neg ? -mag_r : mag_r);
      divu_q  = b_zero ? '1 : src_a / b_safe;
      divu_r  = b_zero ? src_a : src_a % b_safe;
      // Sign/zero-extending to 2*WIDTH makes the low 2*WIDTH bits of an
      // unsigned multiply equal to the signed product.
      prod_s  = {{WIDTH{a_neg}}, src_a} * {{WIDTH{b_neg}}, src_b};
      prod_u  = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy    <= 1'b0;
         counter <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (busy) begin
         // Requests while busy are dropped; the hazard unit never issues them.
         if (counter == CNT_W'(1)) begin
            hi      <= pend_hi;
            lo      <= pend_lo;
            busy    <= 1'b0;
            counter <= '0;
         end else begin
            counter <= counter - CNT_W'(1);
         end
      end else if (start) begin
         case (op)
            MDU_mult: begin
               {pend_hi, pend_lo} <= prod_s;
               counter            <= CNT_W'(MUL_CYCLES);
               busy               <= 1'b1;
            end
            MDU_multu: begin
               {pend_hi, pend_lo} <= prod_u;
               counter            <= CNT_W'(MUL_CYCLES);
               busy               <= 1'b1;
            end
            MDU_div: begin
               pend_lo <= div_q;
               pend_hi <= div_r;
               counter <= CNT_W'(DIV_CYCLES);
               busy    <= 1'b1;
            end
            MDU_divu: begin
               pend_lo <= divu_q;
               pend_hi <= divu_r;
               counter <= CNT_W'(DIV_CYCLES);
               busy    <= 1'b1;
            end
            MDU_mthi: hi <= src_a;
            MDU_mtlo: lo <= src_a;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if (op == MDU_mfhi) begin
         rd_data = hi;
      end else if (op == MDU_mflo) begin
         rd_data = lo;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int unsigned MUL = 5;
   localparam int unsigned DIV = 10;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [OP_W-1:0] op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mult_div_unit #(
      .WIDTH      (32),
      .MUL_CYCLES (MUL),
      .DIV_CYCLES (DIV)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .rd_data (rd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t model(input logic [OP_W-1:0] o, input logic [31:0] a,
                                  input logic [31:0] b);
      longint sa;
      longint sb2;
      longint q;
      longint r;
      logic [63:0] p;
      exp_t e;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      e   = '0;
      if (o == MDU_mult) begin
         p = 64'(sa * sb2);
         e = {p[63:32], p[31:0]};
      end else if (o == MDU_multu) begin
         p = {32'd0, a} * {32'd0, b};
         e = {p[63:32], p[31:0]};
      end else if (b == 32'd0) begin
         e = {a, 32'hFFFF_FFFF};
      end else if (o == MDU_div) begin
         q = sa / sb2;
         r = sa % sb2;
         e = {r[31:0], q[31:0]};
      end else begin
         e = {a % b, a / b};
      end
      return e;
   endfunction

   function automatic bit is_mul(input logic [OP_W-1:0] o);
      return (o == MDU_mult) || (o == MDU_multu);
   endfunction

   // Drives one request for a single cycle and records what it should produce.
   task automatic issue(input logic [OP_W-1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      if (o == MDU_mult || o == MDU_multu || o == MDU_div || o == MDU_divu)
         sb.push_back(model(o, a, b));
      else if (o == MDU_mthi)
         model_hi = a;
      else if (o == MDU_mtlo)
         model_lo = a;
      @(negedge clk);
      start = 1'b0;
      op    = MDU_none;
   endtask

   // Counts busy cycles (sampled at negedges) until busy falls, bounded.
   task automatic wait_commit(output int cyc, output bit to);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      to = (busy !== 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      op      = MDU_mfhi;
      src_a   = '0;
      src_b   = '0;
      #12;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
      total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd: got %h want 0", rd_data); end
      op = MDU_none;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      logic [OP_W-1:0] ops[4] = '{MDU_mult, MDU_multu, MDU_mult, MDU_multu};
      logic [31:0] as[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h1234_5678};
      logic [31:0] bs[4] = '{32'h2, 32'h2, 32'hFFFF_FFFD, 32'h9ABC_DEF0};
      int cyc;
      bit to;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_commit(cyc, to);
         e = sb.pop_front();
         total++; if (to || cyc != MUL) begin bad++; $display("FAIL mult_busy[%0d]: got %0d want %0d", i, cyc, MUL); end
         total++; if (hi !== e.hi) begin bad++; $display("FAIL mult_hi[%0d]: got %h want %h", i, hi, e.hi); end
         total++; if (lo !== e.lo) begin bad++; $display("FAIL mult_lo[%0d]: got %h want %h", i, lo, e.lo); end
         model_hi = e.hi;
         model_lo = e.lo;
      end
   endtask

   task automatic test_div();
      logic [OP_W-1:0] ops[6] = '{MDU_div, MDU_divu, MDU_div, MDU_div, MDU_div, MDU_divu};
      logic [31:0] as[6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      logic [31:0] bs[6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd3};
      int cyc;
      bit to;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_commit(cyc, to);
         e = sb.pop_front();
         total++; if (to || cyc != DIV) begin bad++; $display("FAIL div_busy[%0d]: got %0d want %0d", i, cyc, DIV); end
         total++; if (hi !== e.hi) begin bad++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, e.hi); end
         total++; if (lo !== e.lo) begin bad++; $display("FAIL div_lo[%0d]: got %h want %h", i, lo, e.lo); end
         model_hi = e.hi;
         model_lo = e.lo;
      end
   endtask

   task automatic test_move();
      issue(MDU_mthi, 32'h1234, 32'd0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
      total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
      op = MDU_mflo;
      #1;
      total++; if (rd_data !== model_lo) begin bad++; $display("FAIL mflo_rd: got %h want %h", rd_data, model_lo); end
      op = MDU_mfhi;
      #1;
      total++; if (rd_data !== 32'h1234) begin bad++; $display("FAIL mfhi_rd: got %h want 00001234", rd_data); end
      op = MDU_none;
      #1;
      total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL none_rd: got %h want 0", rd_data); end
      @(negedge clk);
      issue(MDU_mtlo, 32'hCAFE_F00D, 32'd0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
      total++; if (lo !== 32'hCAFE_F00D) begin bad++; $display("FAIL mtlo_lo: got %h want cafef00d", lo); end
      total++; if (hi !== model_hi) begin bad++; $display("FAIL mtlo_hi: got %h want %h", hi, model_hi); end
   endtask

   task automatic test_unknown();
      start = 1'b1;
      op    = 4'd12;
      src_a = 32'hDEAD_BEEF;
      src_b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      op    = MDU_none;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL unk_busy: got %b want 0", busy); end
      total++; if (hi !== model_hi) begin bad++; $display("FAIL unk_hi: got %h want %h", hi, model_hi); end
      total++; if (lo !== model_lo) begin bad++; $display("FAIL unk_lo: got %h want %h", lo, model_lo); end
   endtask

   task automatic test_busy_ignored();
      int cyc;
      bit to;
      exp_t e;
      issue(MDU_mult, 32'd3, 32'd4);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", busy); end
      total++; if (hi !== model_hi || lo !== model_lo) begin
         bad++; $display("FAIL ign_pending: got %h_%h want %h_%h", hi, lo, model_hi, model_lo);
      end
      start = 1'b1;
      op    = MDU_mult;
      src_a = 32'd100;
      src_b = 32'd100;
      wait_commit(cyc, to);
      start = 1'b0;
      op    = MDU_none;
      e = sb.pop_front();
      total++; if (to || cyc != MUL) begin bad++; $display("FAIL ign_cycles: got %0d want %0d", cyc, MUL); end
      total++; if (hi !== e.hi || lo !== e.lo) begin
         bad++; $display("FAIL ign_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
      end
      model_hi = e.hi;
      model_lo = e.lo;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit to;
      exp_t e;
      issue(MDU_multu, 32'd10, 32'd20);
      wait_commit(cyc, to);
      e = sb.pop_front();
      total++; if (to || lo !== e.lo || hi !== e.hi) begin
         bad++; $display("FAIL b2b_first: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
      end
      issue(MDU_div, 32'd100, 32'd7);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
      wait_commit(cyc, to);
      e = sb.pop_front();
      total++; if (to || cyc != DIV) begin bad++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, DIV); end
      total++; if (hi !== e.hi || lo !== e.lo) begin
         bad++; $display("FAIL b2b_second: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
      end
      model_hi = e.hi;
      model_lo = e.lo;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      issue(MDU_div, 32'd50, 32'd3);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      total++; if (hi !== 32'd0 || lo !== 32'd0) begin
         bad++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", hi, lo);
      end
      e = sb.pop_front();
      model_hi = '0;
      model_lo = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         bad++; $display("FAIL rstmid_after: got %b %h_%h want 0 0_0", busy, hi, lo);
      end
   endtask

   task automatic test_random();
      logic [OP_W-1:0] ops[4] = '{MDU_mult, MDU_multu, MDU_div, MDU_divu};
      logic [OP_W-1:0] o;
      logic [31:0] a;
      logic [31:0] b;
      int cyc;
      int want;
      bit to;
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         o = ops[$urandom_range(0, 3)];
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         want = is_mul(o) ? MUL : DIV;
         issue(o, a, b);
         wait_commit(cyc, to);
         e = sb.pop_front();
         total++; if (to || cyc != want) begin bad++; $display("FAIL rnd_cycles[%0d]: got %0d want %0d", i, cyc, want); end
         total++; if (hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h",
                            i, o, a, b, hi, lo, e.hi, e.lo);
         end
         model_hi = e.hi;
         model_lo = e.lo;
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_move();
      test_unknown();
      test_busy_ignored();
      test_back_to_back();
      test_reset_mid();
      test_random();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_empty: got %0d want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
